ddr3_req_arbiter: RTL
=====================

# ddr3_req_arbiter

Two-port request arbiter that shares the single DDR3 controller request/data port between two bus-side requesters: A, the USB BULK OUT/IN datapath, and B, the telemetry/logging writer. It serialises commands with round-robin grant and routes write beats from the granted requester. It also returns read beats to the requester that issued each read, in issue order. It sits in the `bus_clock` domain, in front of the DDR3 controller's AXI-style command/data streams.

## Interface
- `ADDR_WIDTH`, 27: word address width.
- `DATA_WIDTH`, 32: write/read beat width.
- `LEN_WIDTH`, 8: burst length field width; value is beats-1.
- `RD_DEPTH`, 4: outstanding-read order FIFO depth; power of two, at least 2.
- `clock`  in  1  bus clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `{a,b}_cmd_valid` / `{a,b}_cmd_ready`  in/out  1  requester command handshake.
- `{a,b}_cmd_write`  in  1  1 = write, 0 = read.
- `{a,b}_cmd_addr`  in  ADDR_WIDTH  start address.
- `{a,b}_cmd_len`  in  LEN_WIDTH  beats-1.
- `{a,b}_wr_valid` / `{a,b}_wr_ready`  in/out  1  write-data handshake.
- `{a,b}_wr_last`  in  1  final write beat.
- `{a,b}_wr_data`  in  DATA_WIDTH  write data.
- `{a,b}_rd_valid` / `{a,b}_rd_ready`  out/in  1  read-data handshake.
- `{a,b}_rd_last`  out  1  final read beat.
- `{a,b}_rd_data`  out  DATA_WIDTH  read data.
- `m_cmd_valid` / `m_cmd_ready`  out/in  1  controller command handshake.
- `m_cmd_write`, `m_cmd_addr`, `m_cmd_len`  out  1/ADDR_WIDTH/LEN_WIDTH  forwarded command fields.
- `m_wr_valid` / `m_wr_ready`  out/in  1  controller write-data handshake.
- `m_wr_last`, `m_wr_data`  out  1/DATA_WIDTH  forwarded write beat.
- `m_rd_valid` / `m_rd_ready`  in/out  1  controller read-data handshake.
- `m_rd_last`, `m_rd_data`  in  1/DATA_WIDTH  returned read beat.
- `rd_pending_o`  out  $clog2(RD_DEPTH)+1  reads issued whose last beat has not yet returned.

## Operation
- The state machine has three states.
  - IDLE: evaluate eligible requesters, register `sel`, go to CMD. If none is eligible, stay in IDLE.
  - CMD: `m_cmd_*` = `sel` requester's fields; `m_cmd_valid` = `sel_cmd_valid`; `sel_cmd_ready` = `m_cmd_ready`. On handshake, go to WDATA for a write and to IDLE for a read.
  - WDATA: `m_wr_*` ↔ `sel_wr_*` combinational pass-through. On handshake with `wr_last`, go to IDLE. The other requester's `wr_ready` stays 0.
- Eligibility: requester's `cmd_valid`=1, and, if `cmd_write`=0, order FIFO not full.
  - A read is blocked while the FIFO is full; a write from the other requester can still win.
- Round-robin: `last` register, reset value A. When both are eligible, grant the requester ≠ `last`. `last` updates on each command handshake.
- Order FIFO:
  - Push the requester id on a read-command handshake.
  - The FIFO head selects the read-return destination: `m_rd_ready` = `head_rd_ready`; only the head requester sees `rd_valid`.
  - Pop on an `m_rd_valid & m_rd_ready & m_rd_last` beat.
  - Simultaneous push and pop leaves the count unchanged.
  - FIFO empty ⇒ `m_rd_ready`=0 and both `rd_valid`=0; read data is never dropped.
- Requesters hold `cmd_valid` and fields stable until `cmd_ready` is seen.

## Timing
- Reset values: all `*_ready` outputs 0, `m_cmd_valid`=0, `m_wr_valid`=0, `{a,b}_rd_valid`=0, `rd_pending_o`=0, state IDLE, FIFO empty, `last`=A.
- Arbitration latency: 1 cycle from `cmd_valid` (seen in IDLE) to `m_cmd_valid`.
- A command accepted in cycle n allows the next command to present no earlier than n+2, so peak rate is one read per 2 cycles.
- Write data and read data have 0-cycle added latency (combinational muxes).
- `reset` mid-burst aborts the WDATA burst, clears the FIFO and returns to IDLE next cycle. Software re-initialises the controller as well.

## Configuration
- `DDR3_ARB_FIXED_PRIO_EN` defined: A always wins when both are eligible, and `last` is unused.
- `DDR3_ARB_FIXED_PRIO_EN` undefined: round-robin as above.

## Structure
- Package `ddr3_arb_pkg`: state encoding (`ST_IDLE`, `ST_CMD`, `ST_WDATA`) and requester ids (`REQ_A`=0, `REQ_B`=1).
- Sub-module `ddr3_arb_order_fifo`: 1-bit-wide synchronous FIFO of depth `RD_DEPTH` with full/empty/count outputs; it drives `rd_pending_o`.

## Test plan
- A write, len=3, 4 beats, idle B → `m_cmd_valid` one cycle after `a_cmd_valid`; 4 beats pass with `m_wr_last` on beat 4; `b_wr_ready`=0 throughout.
- A and B both hold read commands continuously → grants alternate B, A, B, A (first grant is B because `last`=A at reset); with the macro defined, A, A, A.
- 5 reads from A with RD_DEPTH=4 and no read data returned → 4 accepted, `rd_pending_o`=4, 5th stalls; a write from B is still granted.
- Reads issued A then B; controller returns 2 bursts → first burst reaches `a_rd_*` only, second reaches `b_rd_*` only; `rd_pending_o` goes 2→1→0 on each last beat.
- Head requester deasserts `rd_ready` mid-burst → `m_rd_ready`=0 that cycle, no beat lost or duplicated.
- `reset` asserted during beat 2 of an 8-beat write → next cycle all ready/valid outputs are 0, state IDLE, `rd_pending_o`=0.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared encodings for the DDR3 request arbiter: FSM states, requester ids
// and the round-robin pick helper.
package ddr3_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // When both requesters are eligible, the one that did not win last time goes.
  function automatic logic rr_pick(input logic elig_a, input logic elig_b, input logic last);
    if (elig_a && elig_b) return ~last;
    else if (elig_b)      return REQ_B;
    else                  return REQ_A;
  endfunction

endpackage

// File: rtl/ddr3_arb_order_fifo.sv
// Read-return order FIFO: one requester id per outstanding read command,
// head selects where returning read beats are routed.
module ddr3_arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_id,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_id;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Two-requester DDR3 command/data arbiter with in-order read return routing.
// Define DDR3_ARB_FIXED_PRIO_EN to make requester A win every tie.
//
// state    | meaning
// ST_IDLE  | pick an eligible requester, latch it in r_sel
// ST_CMD   | forward r_sel command to the controller until handshake
// ST_WDATA | pass r_sel write beats through until the last one
module ddr3_req_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_cmd_valid,
  output logic                    a_cmd_ready,
  input  logic                    a_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   a_cmd_addr,
  input  logic [LEN_WIDTH-1:0]    a_cmd_len,
  input  logic                    a_wr_valid,
  output logic                    a_wr_ready,
  input  logic                    a_wr_last,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  output logic                    a_rd_valid,
  input  logic                    a_rd_ready,
  output logic                    a_rd_last,
  output logic [DATA_WIDTH-1:0]   a_rd_data,
  input  logic                    b_cmd_valid,
  output logic                    b_cmd_ready,
  input  logic                    b_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   b_cmd_addr,
  input  logic [LEN_WIDTH-1:0]    b_cmd_len,
  input  logic                    b_wr_valid,
  output logic                    b_wr_ready,
  input  logic                    b_wr_last,
  input  logic [DATA_WIDTH-1:0]   b_wr_data,
  output logic                    b_rd_valid,
  input  logic                    b_rd_ready,
  output logic                    b_rd_last,
  output logic [DATA_WIDTH-1:0]   b_rd_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic                    m_cmd_write,
  output logic [ADDR_WIDTH-1:0]   m_cmd_addr,
  output logic [LEN_WIDTH-1:0]    m_cmd_len,
  output logic                    m_wr_valid,
  input  logic                    m_wr_ready,
  output logic                    m_wr_last,
  output logic [DATA_WIDTH-1:0]   m_wr_data,
  input  logic                    m_rd_valid,
  output logic                    m_rd_ready,
  input  logic                    m_rd_last,
  input  logic [DATA_WIDTH-1:0]   m_rd_data,
  output logic [$clog2(RD_DEPTH):0] rd_pending_o
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       w_pick;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_elig_a;
  logic       w_elig_b;
  logic       w_sel_cmd_valid;
  logic       w_sel_wr_valid;
  logic       w_cmd_hs;
  logic       w_push;
  logic       w_pop;

  // Reads need a free order slot; writes never touch the FIFO.
  assign w_elig_a = a_cmd_valid & (a_cmd_write | ~w_full);
  assign w_elig_b = b_cmd_valid & (b_cmd_write | ~w_full);

  assign w_sel_cmd_valid = r_sel ? b_cmd_valid : a_cmd_valid;
  assign w_sel_wr_valid  = r_sel ? b_wr_valid  : a_wr_valid;
  assign m_cmd_write     = r_sel ? b_cmd_write : a_cmd_write;
  assign m_cmd_addr      = r_sel ? b_cmd_addr  : a_cmd_addr;
  assign m_cmd_len       = r_sel ? b_cmd_len   : a_cmd_len;
  assign m_wr_last       = r_sel ? b_wr_last   : a_wr_last;
  assign m_wr_data       = r_sel ? b_wr_data   : a_wr_data;

  assign w_cmd_hs = (r_state == ST_CMD) & w_sel_cmd_valid & m_cmd_ready;
  assign w_push   = w_cmd_hs & ~m_cmd_write;
  assign w_pop    = m_rd_valid & m_rd_ready & m_rd_last;

`ifdef DDR3_ARB_FIXED_PRIO_EN
  assign w_pick = w_elig_a ? REQ_A : REQ_B;
`else
  logic r_last;
  assign w_pick = rr_pick(w_elig_a, w_elig_b, r_last);

  always_ff @(posedge clock) begin
    if (reset)         r_last <= REQ_A;
    else if (w_cmd_hs) r_last <= r_sel;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= REQ_A;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    m_cmd_valid = 1'b0;
    a_cmd_ready = 1'b0;
    b_cmd_ready = 1'b0;
    m_wr_valid  = 1'b0;
    a_wr_ready  = 1'b0;
    b_wr_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig_a || w_elig_b) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        m_cmd_valid = w_sel_cmd_valid;
        a_cmd_ready = (r_sel == REQ_A) & m_cmd_ready;
        b_cmd_ready = (r_sel == REQ_B) & m_cmd_ready;
        if (w_cmd_hs) w_state_nxt = m_cmd_write ? ST_WDATA : ST_IDLE;
      end
      ST_WDATA: begin
        m_wr_valid = w_sel_wr_valid;
        a_wr_ready = (r_sel == REQ_A) & m_wr_ready;
        b_wr_ready = (r_sel == REQ_B) & m_wr_ready;
        if (w_sel_wr_valid && m_wr_ready && m_wr_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read beats go only to the requester at the FIFO head; nothing flows when empty.
  assign m_rd_ready = ~w_empty & (w_head ? b_rd_ready : a_rd_ready);
  assign a_rd_valid = ~w_empty & ~w_head & m_rd_valid;
  assign b_rd_valid = ~w_empty &  w_head & m_rd_valid;
  assign a_rd_last  = m_rd_last;
  assign b_rd_last  = m_rd_last;
  assign a_rd_data  = m_rd_data;
  assign b_rd_data  = m_rd_data;

  ddr3_arb_order_fifo #(
    .DEPTH(RD_DEPTH)
  ) u_order_fifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_id    (r_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (rd_pending_o)
  );

endmodule
